pixel_frame_writer: RTL



---
 rtl/pixel_frame_writer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pixel_frame_writer.sv
// Streams RGB pixels from an AXI-Stream style input through a skid FIFO into a frame buffer.
// Optional upstream stall counter is enabled by defining PIXEL_FRAME_WRITER_STALL_COUNT_EN.
module pixel_frame_writer #(
    parameter  int H_RES      = 320,
    parameter  int V_RES      = 180,
    parameter  int FIFO_DEPTH = 4,
    localparam int ADDR_W     = $clog2(H_RES * V_RES)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [23:0]       pixel_axis_tdata,
    input  logic              pixel_axis_tvalid,
    output logic              pixel_axis_tready,
    input  logic              frame_start,
    input  logic              fb_wr_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       stall_count
);

    localparam int TOTAL = H_RES * V_RES;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]  widx_q, widx_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     occ_q, occ_d;
    logic [23:0]        mem_q [FIFO_DEPTH];
    logic [23:0]        mem_d [FIFO_DEPTH];
    logic               fifo_empty, fifo_full, push, pop;

    // Outputs decode registered state only, so fb_wr_ready never reaches tready.
    always_comb begin
        fifo_empty        = (occ_q == '0);
        fifo_full         = (occ_q == (PTR_W+1)'(FIFO_DEPTH));
        pixel_axis_tready = (state_q == S_ACTIVE) && !fifo_full;
        push              = pixel_axis_tvalid && pixel_axis_tready;
        fb_we             = !fifo_empty && fb_wr_ready;
        pop               = fb_we;
        fb_data           = fifo_empty ? 24'h0 : mem_q[rd_ptr_q];
        fb_addr           = widx_q;
        busy              = (state_q != S_IDLE);
        frame_done        = (state_q == S_DONE);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        widx_d   = widx_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        mem_d    = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = pixel_axis_tdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            widx_d   = (widx_q == ADDR_W'(TOTAL - 1)) ? '0 : widx_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_ACTIVE;
                    acc_d   = '0;
                    widx_d  = '0;
                end
            end
            S_ACTIVE: begin
                if (push) begin
                    acc_d = acc_q + 1'b1;
                    if (acc_q == CNT_W'(TOTAL - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            widx_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            widx_q   <= widx_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            mem_q    <= mem_d;
        end
    end

`ifdef PIXEL_FRAME_WRITER_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && frame_start)
            stall_d = '0;
        else if (busy && pixel_axis_tvalid && !pixel_axis_tready && stall_q != 16'hFFFF)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0;
`endif

endmodule
